multi_debounce_counter: RTL and testbench

Parametrised N-channel debounced event counter for push-buttons and slide switches on the board I/O. Each channel synchronises its raw input and filters bounce with a stability timer. It then counts qualifying edges (rising, falling or both) up or down into its own counter, with wrap or saturate selectable. All channels are independent, so simultaneous events on different channels are never dropped.

---
 rtl/multi_debounce_pkg.sv | 27 ++
 rtl/debounce_channel.sv | 54 +++++
 rtl/multi_debounce_counter.sv | 105 ++++++++++
 tb/tb_multi_debounce_counter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_debounce_pkg.sv
// Shared encodings for the multi-channel debounced event counter.
package multi_debounce_pkg;

    // Per-channel edge selection carried on mode[2i+1:2i].
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    // Count direction carried on dir[i].
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // True when a debounced edge is one the channel's mode asks us to count.
    function automatic logic edge_qualifies(input logic [1:0] m,
                                            input logic       rise,
                                            input logic       fall);
        logic want_rise;
        logic want_fall;
        want_rise = (m == MODE_RISE) || (m == MODE_BOTH);
        want_fall = (m == MODE_FALL) || (m == MODE_BOTH);
        return (rise && want_rise) || (fall && want_fall);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchroniser, stability timer and debounced level.
// rise/fall are combinational strobes that are high in the cycle before level
// changes, so a consumer registering on them updates on the same edge as level.
module debounce_channel #(
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [DB_W-1:0] TIMER_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      sync_q,  sync_d;
    logic [DB_W-1:0] timer_q, timer_d;
    logic            level_q, level_d;

    // Synchroniser shift and stability timer; any return to the current level restarts the count.
    always_comb begin
        sync_d  = {sync_q[0], in_raw};
        timer_d = timer_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            level_d = sync_q[1];
            timer_d = '0;
        end else begin
            timer_d = timer_q + DB_W'(1);
        end
    end

    // State registers; reset clears everything without needing a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            timer_q <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            timer_q <= timer_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign rise  = level_d & ~level_q;
    assign fall  = ~level_d & level_q;

endmodule

// File: rtl/multi_debounce_counter.sv
// N independent debounced event counters with selectable edge, direction and
// wrap/saturate behaviour. Each channel has its own debouncer and counter, so
// coincident events on different channels are all counted.
module multi_debounce_counter
    import multi_debounce_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 7,
    parameter int DB_CYCLES = 50000,
    parameter int DB_W      = 16,
    parameter int SATURATE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       in_raw,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [N_CH-1:0]       dir,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       level,
    output logic [N_CH-1:0]       evt,
    output logic [N_CH*CNT_W-1:0] count,
    output logic [N_CH-1:0]       wrap
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

    // Returns {limit_hit, next_count}; limit_hit flags a wrap or a clamped step.
    function automatic logic [CNT_W:0] step_count(input logic [CNT_W-1:0] cur,
                                                  input logic             down);
        logic [CNT_W-1:0] nxt;
        logic             hit;
        hit = down ? (cur == CNT_MIN) : (cur == CNT_MAX);
        if (hit && (SATURATE != 0)) begin
            nxt = cur;
        end else if (down) begin
            nxt = cur - CNT_W'(1);
        end else begin
            nxt = cur + CNT_W'(1);
        end
        return {hit, nxt};
    endfunction

    logic [N_CH-1:0]            rise;
    logic [N_CH-1:0]            fall;
    logic [N_CH-1:0]            qual;
    logic [N_CH-1:0][CNT_W:0]   step_res;

    logic [N_CH-1:0][CNT_W-1:0] count_q, count_d;
    logic [N_CH-1:0]            wrap_q,  wrap_d;
    logic [N_CH-1:0]            evt_q,   evt_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .DB_W      (DB_W)
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .in_raw (in_raw[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );

        // mode and dir are used live, so a change takes effect on the very next edge.
        assign qual[i]     = edge_qualifies(mode[2*i +: 2], rise[i], fall[i]);
        assign step_res[i] = step_count(count_q[i], dir[i] == DIR_DN);
    end

    // Next count/wrap/event per channel; clear wins over a coincident step but the event still shows.
    always_comb begin
        count_d = count_q;
        wrap_d  = wrap_q;
        evt_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            evt_d[i] = qual[i];
            if (clr[i]) begin
                count_d[i] = '0;
                wrap_d[i]  = 1'b0;
            end else if (qual[i]) begin
                count_d[i] = step_res[i][CNT_W-1:0];
                wrap_d[i]  = wrap_q[i] | step_res[i][CNT_W];
            end
        end
    end

    // Counter, sticky wrap and event registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= '0;
            evt_q   <= '0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            evt_q   <= evt_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign evt   = evt_q;

endmodule

// File: tb/tb_multi_debounce_counter.sv
// Bench for multi_debounce_counter: a wrap instance and a saturate instance
// share the stimulus; a sample-window model predicts both every cycle.
module tb_multi_debounce_counter;

    localparam int NC   = 4;
    localparam int CW   = 3;
    localparam int DB   = 4;
    localparam int MAXV = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NC-1:0]    in_raw = '0;
    logic [2*NC-1:0]  mode   = '0;
    logic [NC-1:0]    dir    = '0;
    logic [NC-1:0]    clr    = '0;

    logic [NC-1:0]    level_w, evt_w, wrap_w;
    logic [NC-1:0]    level_s, evt_s, wrap_s;
    logic [NC*CW-1:0] count_w, count_s;

    int total = 0;
    int bad   = 0;
    int nevt_w [NC];

    always #5 clk = ~clk;

    multi_debounce_counter #(
        .N_CH(NC), .CNT_W(CW), .DB_CYCLES(DB), .DB_W(16), .SATURATE(0)
    ) dut_w (
        .clk(clk), .rst(rst), .in_raw(in_raw), .mode(mode), .dir(dir), .clr(clr),
        .level(level_w), .evt(evt_w), .count(count_w), .wrap(wrap_w)
    );

    multi_debounce_counter #(
        .N_CH(NC), .CNT_W(CW), .DB_CYCLES(DB), .DB_W(16), .SATURATE(1)
    ) dut_s (
        .clk(clk), .rst(rst), .in_raw(in_raw), .mode(mode), .dir(dir), .clr(clr),
        .level(level_s), .evt(evt_s), .count(count_s), .wrap(wrap_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_of(input logic [NC*CW-1:0] v, input int ch);
        return int'(v[CW*ch +: CW]);
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: raw input is seen two edges late; level flips once the last DB
    // samples all disagree with it. Counts are plain integers clamped or folded.
    logic [NC-1:0] r1 = '0, r2 = '0;
    int  hist  [NC][DB];
    bit  lvl_m [NC];
    bit  evt_m [NC];
    int  cnt_m [2][NC];
    bit  wrp_m [2][NC];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r1 = '0;
            r2 = '0;
            for (int c = 0; c < NC; c++) begin
                for (int j = 0; j < DB; j++) hist[c][j] = 0;
                lvl_m[c] = 0;
                evt_m[c] = 0;
                for (int s = 0; s < 2; s++) begin
                    cnt_m[s][c] = 0;
                    wrp_m[s][c] = 0;
                end
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                bit all_diff;
                bit rising;
                logic [1:0] m;
                for (int j = DB - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
                hist[c][0] = int'(r2[c]);
                all_diff = 1;
                for (int j = 0; j < DB; j++)
                    if (hist[c][j] == int'(lvl_m[c])) all_diff = 0;
                evt_m[c] = 0;
                if (all_diff) begin
                    rising   = !lvl_m[c];
                    lvl_m[c] = !lvl_m[c];
                    m        = mode[2*c +: 2];
                    evt_m[c] = rising ? (m == 2'b01 || m == 2'b11)
                                      : (m == 2'b10 || m == 2'b11);
                end
                for (int s = 0; s < 2; s++) begin
                    if (clr[c]) begin
                        cnt_m[s][c] = 0;
                        wrp_m[s][c] = 0;
                    end else if (evt_m[c]) begin
                        int v;
                        v = cnt_m[s][c] + (dir[c] ? -1 : 1);
                        if (v > MAXV || v < 0) begin
                            wrp_m[s][c] = 1;
                            if (s == 1) cnt_m[s][c] = (v < 0) ? 0 : MAXV;
                            else        cnt_m[s][c] = (v < 0) ? MAXV : 0;
                        end else begin
                            cnt_m[s][c] = v;
                        end
                    end
                end
            end
            r2 = r1;
            r1 = in_raw;
        end
    end

    // Every cycle: both instances against the model, and tally observed events.
    always @(negedge clk) begin
        logic [NC-1:0]    el, ee, ew0, ew1;
        logic [NC*CW-1:0] ec0, ec1;
        for (int c = 0; c < NC; c++) begin
            el[c]  = lvl_m[c];
            ee[c]  = evt_m[c];
            ew0[c] = wrp_m[0][c];
            ew1[c] = wrp_m[1][c];
            ec0[CW*c +: CW] = CW'(cnt_m[0][c]);
            ec1[CW*c +: CW] = CW'(cnt_m[1][c]);
            if (evt_w[c] === 1'b1) nevt_w[c]++;
        end
        chk("model_level_w", level_w, el);
        chk("model_evt_w",   evt_w,   ee);
        chk("model_count_w", count_w, ec0);
        chk("model_wrap_w",  wrap_w,  ew0);
        chk("model_level_s", level_s, el);
        chk("model_evt_s",   evt_s,   ee);
        chk("model_count_s", count_s, ec1);
        chk("model_wrap_s",  wrap_s,  ew1);
    end

    initial begin
        for (int c = 0; c < NC; c++) nevt_w[c] = 0;

        // Reset state
        wait_n(3);
        chk("rst_count", count_w, 0);
        chk("rst_level", level_w, 0);
        chk("rst_wrap",  wrap_w,  0);
        chk("rst_evt",   evt_w,   0);
        rst = 1'b0;
        wait_n(2);

        // Bounce rejection on ch0, rising mode
        mode[1:0] = 2'b01;
        for (int i = 0; i < 12; i++) begin
            in_raw[0] = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        in_raw[0] = 1'b1;
        wait_n(5);
        chk("bounce_level_early", level_w[0], 0);
        chk("bounce_evt_early",   nevt_w[0],  0);
        wait_n(1);
        chk("bounce_level", level_w[0], 1);
        chk("bounce_evt",   evt_w[0],   1);
        chk("bounce_count", cnt_of(count_w, 0), 1);
        wait_n(1);
        chk("bounce_evt_1cyc", evt_w[0], 0);
        wait_n(4);
        chk("bounce_nevt", nevt_w[0], 1);

        // Bring ch0 to 5, then clear on the same cycle as the next rise
        in_raw[0] = 1'b0; wait_n(8);
        for (int k = 0; k < 4; k++) begin
            in_raw[0] = 1'b1; wait_n(8);
            in_raw[0] = 1'b0; wait_n(8);
        end
        chk("pre_clr_count", cnt_of(count_w, 0), 5);
        in_raw[0] = 1'b1;
        wait_n(5);
        clr[0] = 1'b1;
        wait_n(1);
        clr[0] = 1'b0;
        chk("clr_evt",   evt_w[0], 1);
        chk("clr_count", cnt_of(count_w, 0), 0);
        chk("clr_wrap",  wrap_w[0], 0);
        wait_n(2);

        // Both edges, counting down on ch1
        mode[3:2] = 2'b11;
        dir[1]    = 1'b1;
        in_raw[1] = 1'b1;
        wait_n(6);
        chk("down_evt1",   evt_w[1], 1);
        chk("down_count1", cnt_of(count_w, 1), 7);
        chk("down_wrap1",  wrap_w[1], 1);
        wait_n(2);
        in_raw[1] = 1'b0;
        wait_n(6);
        chk("down_evt2",   evt_w[1], 1);
        chk("down_count2", cnt_of(count_w, 1), 6);
        chk("down_wrap2",  wrap_w[1], 1);
        chk("down_sat_count", cnt_of(count_s, 1), 0);
        wait_n(2);
        chk("down_nevt", nevt_w[1], 2);

        // Saturate vs wrap on ch2, nine clean rising edges
        mode[5:4] = 2'b01;
        for (int k = 1; k <= 9; k++) begin
            in_raw[2] = 1'b1;
            wait_n(6);
            chk("sat_count",  cnt_of(count_s, 2), (k > 7) ? 7 : k);
            chk("sat_wrap",   wrap_s[2], (k >= 8) ? 1 : 0);
            chk("wrap_count", cnt_of(count_w, 2), k % 8);
            wait_n(2);
            in_raw[2] = 1'b0;
            wait_n(8);
        end

        // Simultaneous rises on all channels
        in_raw = '0;
        mode   = 8'b01010101;
        dir    = '0;
        wait_n(8);
        in_raw = 4'hF;
        wait_n(6);
        chk("simul_evt_w", evt_w, 4'hF);
        chk("simul_evt_s", evt_s, 4'hF);
        chk("simul_cnt0",  cnt_of(count_w, 0), 1);
        chk("simul_cnt1",  cnt_of(count_w, 1), 7);
        chk("simul_cnt2",  cnt_of(count_w, 2), 2);
        chk("simul_cnt3",  cnt_of(count_w, 3), 1);
        wait_n(2);
        in_raw = '0;
        wait_n(8);
        mode[7:6] = 2'b00;
        in_raw = 4'hF;
        wait_n(6);
        chk("off_evt",    evt_w, 4'b0111);
        chk("off_level",  level_w, 4'hF);
        chk("off_cnt3",   cnt_of(count_w, 3), 1);
        chk("off_cnt0",   cnt_of(count_w, 0), 2);
        wait_n(2);

        // Asynchronous reset while ch0 is mid-qualification
        in_raw = '0;
        wait_n(8);
        mode = 8'h01;
        in_raw[0] = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count_w", count_w, 0);
        chk("arst_count_s", count_s, 0);
        chk("arst_wrap",    wrap_w,  0);
        chk("arst_level",   level_w, 0);
        chk("arst_evt",     evt_w,   0);
        wait_n(2);
        rst = 1'b0;
        wait_n(5);
        chk("post_rst_evt_early", evt_w[0], 0);
        chk("post_rst_lvl_early", level_w[0], 0);
        wait_n(1);
        chk("post_rst_evt",   evt_w[0], 1);
        chk("post_rst_level", level_w[0], 1);
        chk("post_rst_count", cnt_of(count_w, 0), 1);
        wait_n(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
